// File: rtl/nf_reg_dump_if.sv
// rtl/nf_reg_dump_if.sv - byte stream from the register dumper to the debug UART transmitter
interface nf_reg_dump_if;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;

    modport master (
        output tx_data,
        output tx_valid,
        input  tx_ready
    );

    modport slave (
        input  tx_data,
        input  tx_valid,
        output tx_ready
    );
endinterface

// File: rtl/nf_reg_dump.sv
// rtl/nf_reg_dump.sv - walks the register file debug port and streams a header plus
// every register, little-endian, as a byte frame
module nf_reg_dump #(
    parameter int          REG_NUMBER = 32,
    parameter logic [7:0]  HEADER     = 8'hA5
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    output logic                 busy,
    output logic                 done,
    output logic [4:0]           ra0,
    input  logic [31:0]          rd0,
    nf_reg_dump_if.master        tx
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR,
        S_LOAD,
        S_SEND,
        S_DONE
    } state_t;

    localparam logic [4:0] LAST_IDX = 5'(REG_NUMBER - 1);

    state_t      state_q, state_d;
    logic [4:0]  idx_q, idx_d;
    logic [4:0]  ra0_q, ra0_d;
    logic [1:0]  byte_cnt_q, byte_cnt_d;
    logic [31:0] shreg_q, shreg_d;
    logic [7:0]  tx_data_c;
    logic        tx_valid_c;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            idx_q      <= 5'd0;
            ra0_q      <= 5'd0;
            byte_cnt_q <= 2'd0;
            shreg_q    <= 32'd0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            ra0_q      <= ra0_d;
            byte_cnt_q <= byte_cnt_d;
            shreg_q    <= shreg_d;
        end
    end

    // tx_data comes only from registered state, so it cannot move during a stall
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        ra0_d      = ra0_q;
        byte_cnt_d = byte_cnt_q;
        shreg_d    = shreg_q;
        busy       = 1'b1;
        done       = 1'b0;
        tx_valid_c = 1'b0;
        tx_data_c  = 8'd0;
        ra0        = ra0_q;

        case (state_q)
            S_IDLE: begin
                busy       = 1'b0;
                ra0        = 5'd0;
                ra0_d      = 5'd0;
                idx_d      = 5'd0;
                byte_cnt_d = 2'd0;
                if (start) begin
                    state_d = S_HDR;
                end
            end
            S_HDR: begin
                tx_valid_c = 1'b1;
                tx_data_c  = HEADER;
                if (tx.tx_ready) begin
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                // rd0 is combinational from ra0, so the word is captured this same cycle
                ra0        = idx_q;
                ra0_d      = idx_q;
                shreg_d    = rd0;
                byte_cnt_d = 2'd0;
                state_d    = S_SEND;
            end
            S_SEND: begin
                tx_valid_c = 1'b1;
                tx_data_c  = shreg_q[7:0];
                if (tx.tx_ready) begin
                    shreg_d    = shreg_q >> 8;
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    if (byte_cnt_q == 2'd3) begin
                        if (idx_q == LAST_IDX) begin
                            state_d = S_DONE;
                        end else begin
                            idx_d   = idx_q + 5'd1;
                            state_d = S_LOAD;
                        end
                    end
                end
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                busy    = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    assign tx.tx_valid = tx_valid_c;
    assign tx.tx_data  = tx_data_c;
endmodule
